core_mem_responder: RTL and testbench

- Memory-side responder for the 5-stage RISC_V core.
- Answers instruction fetch on pc_out with a registered ir.
- Serves MEM-stage load/store requests (address alu_MEM, data writedata_MEM), returns readdata_MEM, and has a programmable wait-state FSM.
- Drives mem_stall back into the core's hazard logic while a data access is outstanding. Includes a program-load port for filling instruction memory.

---
 rtl/core_mem_responder_if.sv | 30 +++
 rtl/core_mem_responder.sv | 161 ++++++++++++++++
 tb/tb_core_mem_responder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_responder_if.sv
// Core <-> memory responder bundle: fetch port, MEM-stage data port and program-load port.
// The core side drives requests (master); the responder answers (slave).
interface core_mem_responder_if;
    logic [31:0] pc_out;
    logic [31:0] ir;
    logic [31:0] alu_MEM;
    logic [31:0] writedata_MEM;
    logic        d_read;
    logic        d_write;
    logic [2:0]  d_funct3;
    logic [31:0] readdata_MEM;
    logic        mem_stall;
    logic        d_ack;
    logic        d_err;
    logic        load_en;
    logic [31:0] load_addr;
    logic [31:0] load_data;

    modport master (
        output pc_out, alu_MEM, writedata_MEM, d_read, d_write, d_funct3,
        output load_en, load_addr, load_data,
        input  ir, readdata_MEM, mem_stall, d_ack, d_err
    );

    modport slave (
        input  pc_out, alu_MEM, writedata_MEM, d_read, d_write, d_funct3,
        input  load_en, load_addr, load_data,
        output ir, readdata_MEM, mem_stall, d_ack, d_err
    );
endinterface

// File: rtl/core_mem_responder.sv
// Memory-side responder for the 5-stage core: registered instruction fetch, program-load port
// and a wait-state data FSM that stalls the pipeline while a load/store is outstanding.
module core_mem_responder #(
    parameter int unsigned IMEM_DEPTH  = 1024,
    parameter int unsigned DMEM_DEPTH  = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic                  clk,
    input logic                  rst,
    core_mem_responder_if.slave  bus
);
    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [32:0] DMEM_BYTES = 33'(DMEM_DEPTH) * 33'd4;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];

    logic [IAW-1:0] fetch_idx;
    logic [IAW-1:0] load_idx;
    logic [DAW-1:0] d_idx;
    logic [31:0]    ir_q;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q;
    logic        access;
    logic        req;
    logic        fault;
    logic [31:0] cur_word;
    logic [31:0] load_val;
    logic [31:0] wr_word;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [4:0]  byte_off;
    logic        unused_bits;

    assign fetch_idx = bus.pc_out[IAW+1:2];
    assign load_idx  = bus.load_addr[IAW+1:2];
    assign d_idx     = bus.alu_MEM[DAW+1:2];
    assign unused_bits = ^{bus.pc_out[31:IAW+2], bus.pc_out[1:0],
                           bus.load_addr[31:IAW+2], bus.load_addr[1:0]};

    // Program load and fetch; the non-blocking write gives read-before-write on a same-index hit.
    always_ff @(posedge clk) begin
        if (bus.load_en) begin
            imem[load_idx] <= bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q <= NOP;
        end else begin
            ir_q <= imem[fetch_idx];
        end
    end

    assign req       = bus.d_read | bus.d_write;
    assign cur_word  = dmem[d_idx];
    assign byte_off  = {bus.alu_MEM[1:0], 3'b000};
    assign lane_byte = 8'(cur_word >> byte_off);
    assign lane_half = bus.alu_MEM[1] ? cur_word[31:16] : cur_word[15:0];

    always_comb begin
        fault    = 1'b0;
        load_val = 32'h0;
        wr_word  = cur_word;
        case (bus.d_funct3)
            3'b000: begin
                load_val = {{24{lane_byte[7]}}, lane_byte};
                wr_word[byte_off +: 8] = bus.writedata_MEM[7:0];
            end
            3'b001: begin
                fault    = bus.alu_MEM[0];
                load_val = {{16{lane_half[15]}}, lane_half};
                if (bus.alu_MEM[1]) begin
                    wr_word[31:16] = bus.writedata_MEM[15:0];
                end else begin
                    wr_word[15:0] = bus.writedata_MEM[15:0];
                end
            end
            3'b010: begin
                fault    = (bus.alu_MEM[1:0] != 2'b00);
                load_val = cur_word;
                wr_word  = bus.writedata_MEM;
            end
            3'b100: begin
                fault    = bus.d_write;
                load_val = {24'h0, lane_byte};
            end
            3'b101: begin
                fault    = bus.d_write | bus.alu_MEM[0];
                load_val = {16'h0, lane_half};
            end
            default: fault = 1'b1;
        endcase
        if ({1'b0, bus.alu_MEM} >= DMEM_BYTES || (bus.d_read && bus.d_write)) begin
            fault = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StBusy;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            StBusy: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // A store leaves the previous load result visible; faults force zero.
    assign rdata_d = fault ? 32'h0 : (bus.d_read ? load_val : rdata_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (access) begin
                rdata_q <= rdata_d;
                err_q   <= fault;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && access && bus.d_write && !fault) begin
            dmem[d_idx] <= wr_word;
        end
    end

    assign bus.ir           = ir_q;
    assign bus.readdata_MEM = rdata_q;
    assign bus.mem_stall    = (state_q == StIdle && req) || (state_q == StBusy);
    assign bus.d_ack        = (state_q == StDone);
    assign bus.d_err        = (state_q == StDone) && err_q;
endmodule

// File: tb/tb_core_mem_responder.sv
// Self-checking bench: a WAIT_CYCLES=2 responder driven from a vector table with a scoreboard,
// plus a WAIT_CYCLES=0 instance for back-to-back accesses.
module tb_core_mem_responder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_mem_responder_if ifa ();
    core_mem_responder_if ifz ();

    core_mem_responder #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024), .WAIT_CYCLES(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    core_mem_responder #(.IMEM_DEPTH(1024), .DMEM_DEPTH(1024), .WAIT_CYCLES(0)) u_dut_z (
        .clk (clk),
        .rst (rst),
        .bus (ifz)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        logic        chk_rd;
        int          id;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];
    exp_t sb_q[$];
    bit   exp_stall [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit   exp_ack   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every d_ack on the main instance must match a queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ifa.d_ack) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got d_ack=1, expected no access pending");
            end else begin
                e = sb_q.pop_front();
                check($sformatf("d_err_vec%0d", e.id), 32'(ifa.d_err), 32'(e.err));
                if (e.chk_rd) begin
                    check($sformatf("rdata_vec%0d", e.id), ifa.readdata_MEM, e.rd);
                end
            end
        end
    end

    task automatic do_access(input vec_t v, input int id);
        exp_t e;
        int   stalls;
        bit   got;
        e.rd = v.exp_rd;
        e.err = v.exp_err;
        e.chk_rd = v.rd | v.exp_err;
        e.id = id;
        sb_q.push_back(e);
        ifa.d_read        = v.rd;
        ifa.d_write       = v.wr;
        ifa.d_funct3      = v.f3;
        ifa.alu_MEM       = v.addr;
        ifa.writedata_MEM = v.wdata;
        stalls = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (ifa.mem_stall) stalls++;
            if (ifa.d_ack) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout_vec%0d: got no d_ack, expected one within 40 cycles", id);
            void'(sb_q.pop_front());
        end
        check($sformatf("stall_len_vec%0d", id), 32'(stalls), 32'd4);
        @(posedge clk);
        #1;
        ifa.d_read  = 1'b0;
        ifa.d_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        rst = 1'b1;
        ifa.pc_out = '0; ifa.alu_MEM = '0; ifa.writedata_MEM = '0; ifa.d_read = 1'b0;
        ifa.d_write = 1'b0; ifa.d_funct3 = '0; ifa.load_en = 1'b0; ifa.load_addr = '0;
        ifa.load_data = '0;
        ifz.pc_out = '0; ifz.alu_MEM = '0; ifz.writedata_MEM = '0; ifz.d_read = 1'b0;
        ifz.d_write = 1'b0; ifz.d_funct3 = '0; ifz.load_en = 1'b0; ifz.load_addr = '0;
        ifz.load_data = '0;

        // rd, wr, funct3, addr, wdata, expected readdata, expected err
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h20,   32'h11223344, 32'h0,        1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b000, 32'h21,   32'hAABBCC80, 32'h0,        1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b010, 32'h20,   32'h0,        32'h11228044, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b000, 32'h21,   32'h0,        32'hFFFFFF80, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b100, 32'h21,   32'h0,        32'h00000080, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b001, 32'h22,   32'h0,        32'h00001122, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b101, 32'h22,   32'h0,        32'h00001122, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b001, 32'h20,   32'h0,        32'hFFFF8044, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b101, 32'h20,   32'h0,        32'h00008044, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b000, 32'h23,   32'h0,        32'h00000011, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b010, 32'h22,   32'h0,        32'h0,        1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h30,   32'hCAFEF00D, 32'h0,        1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b001, 32'h31,   32'h00001234, 32'h0,        1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b1, 3'b010, 32'h30,   32'hFFFFFFFF, 32'h0,        1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b010, 32'h30,   32'h0,        32'hCAFEF00D, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b010, 32'h1000, 32'h0,        32'h0,        1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b000, 32'h1000, 32'h0000005A, 32'h0,        1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b001, 32'h23,   32'h0,        32'h0,        1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b011, 32'h20,   32'h0,        32'h0,        1'b1});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b100, 32'h20,   32'h00000000, 32'h0,        1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b010, 32'h20,   32'h0,        32'h11228044, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 32'h40,   32'h12345678, 32'h0,        1'b0});

        // Reset state, then a request presented during reset must leave the FSM idle.
        repeat (2) @(posedge clk);
        #1;
        check("reset_ir", ifa.ir, 32'h00000013);
        check("reset_rdata", ifa.readdata_MEM, 32'h0);
        check("reset_stall", 32'(ifa.mem_stall), 32'h0);
        check("reset_ack", 32'(ifa.d_ack), 32'h0);
        check("reset_err", 32'(ifa.d_err), 32'h0);
        check("reset_ir_z", ifz.ir, 32'h00000013);
        ifa.d_read = 1'b1;
        @(posedge clk);
        #1;
        ifa.d_read = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_reset_stall%0d", i), 32'(ifa.mem_stall), 32'h0);
            check($sformatf("post_reset_ack%0d", i), 32'(ifa.d_ack), 32'h0);
        end
        @(posedge clk);
        #1;

        // Program load, fetch, index wrap and same-cycle read-before-write.
        ifa.load_en = 1'b1; ifa.load_addr = 32'h0; ifa.load_data = 32'h00500093;
        @(posedge clk); #1;
        ifa.load_addr = 32'h4; ifa.load_data = 32'h00A00113;
        @(posedge clk); #1;
        ifa.load_en = 1'b0; ifa.pc_out = 32'h0;
        @(posedge clk); #1;
        check("fetch_0x0", ifa.ir, 32'h00500093);
        ifa.pc_out = 32'h4;
        @(posedge clk); #1;
        check("fetch_0x4", ifa.ir, 32'h00A00113);
        ifa.pc_out = 32'h1006;
        @(posedge clk); #1;
        check("fetch_wrap", ifa.ir, 32'h00A00113);
        ifa.pc_out = 32'h0;
        ifa.load_en = 1'b1; ifa.load_addr = 32'h0; ifa.load_data = 32'h00100073;
        @(posedge clk); #1;
        check("fetch_rbw_old", ifa.ir, 32'h00500093);
        ifa.load_en = 1'b0;
        @(posedge clk); #1;
        check("fetch_rbw_new", ifa.ir, 32'h00100073);

        foreach (vecs[i]) do_access(vecs[i], i);

        // Reset lands on the edge that would have committed the store.
        ifa.d_write = 1'b1; ifa.d_funct3 = 3'b010; ifa.alu_MEM = 32'h40;
        ifa.writedata_MEM = 32'h00000055;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ifa.d_write = 1'b0;
        @(negedge clk);
        check("abort_stall", 32'(ifa.mem_stall), 32'h0);
        check("abort_ack", 32'(ifa.d_ack), 32'h0);
        @(posedge clk); #1;
        do_access(vec_t'{1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h12345678, 1'b0}, 100);

        // Zero wait states: store, then a held load must run twice, 3 cycles apart.
        ifz.d_write = 1'b1; ifz.d_funct3 = 3'b010; ifz.alu_MEM = 32'h8;
        ifz.writedata_MEM = 32'h0BADF00D;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (ifz.d_ack) got = 1'b1;
        end
        check("z_store_ack", 32'(got), 32'h1);
        @(posedge clk); #1;
        ifz.d_write = 1'b0;
        ifz.d_read = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("b2b_stall_c%0d", i), 32'(ifz.mem_stall), 32'(exp_stall[i]));
            check($sformatf("b2b_ack_c%0d", i), 32'(ifz.d_ack), 32'(exp_ack[i]));
            if (exp_ack[i]) begin
                check($sformatf("b2b_rdata_c%0d", i), ifz.readdata_MEM, 32'h0BADF00D);
                check($sformatf("b2b_err_c%0d", i), 32'(ifz.d_err), 32'h0);
            end
        end
        @(posedge clk); #1;
        ifz.d_read = 1'b0;
        repeat (2) @(posedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
